// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: splits a 32-bit load/store into low then high half-word
// accesses on a 16-bit SRAM, holding ready low until the word is complete.
module mem_access_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rd_en,
    input  logic              i_wr_en,
    input  logic [31:0]       i_address,
    input  logic [31:0]       i_st_val,
    output logic [31:0]       o_rdata,
    output logic              o_ready,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [15:0]       o_sram_wdata,
    input  logic [15:0]       i_sram_rdata,
    output logic              o_sram_we_n,
    output logic              o_sram_oe_n
);
    localparam int CW = $clog2(WAIT_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_op_wr;
    logic [ADDR_W-2:0] r_word;
    logic [31:0]       r_data;
    logic [31:0]       r_rdata;
    logic              r_we_n;
    logic              r_oe_n;
    logic              w_last;
    logic              w_req;
    logic              w_unused;

    assign w_req    = i_rd_en | i_wr_en;
    assign w_last   = (r_cnt == CW'(WAIT_CYCLES - 1));
    assign w_unused = &{1'b0, i_address[31:ADDR_W+1], i_address[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_op_wr <= 1'b0;
            r_word  <= '0;
            r_data  <= '0;
            r_rdata <= '0;
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: if (w_req) begin
                    // a simultaneous rd/wr is taken as a store
                    r_op_wr <= i_wr_en;
                    r_word  <= i_address[ADDR_W:2];
                    r_data  <= i_st_val;
                    r_cnt   <= '0;
                    r_we_n  <= ~i_wr_en;
                    r_oe_n  <= i_wr_en;
                    r_state <= LO;
                end
                LO: if (w_last) begin
                    if (!r_op_wr) r_rdata[15:0] <= i_sram_rdata;
                    r_cnt   <= '0;
                    r_state <= HI;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                HI: if (w_last) begin
                    if (!r_op_wr) r_rdata[31:16] <= i_sram_rdata;
                    r_cnt   <= '0;
                    r_we_n  <= 1'b1;
                    r_oe_n  <= 1'b1;
                    r_state <= DONE;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        o_ready      = 1'b0;
        o_sram_addr  = '0;
        o_sram_wdata = '0;
        case (r_state)
            IDLE: o_ready = ~w_req;
            LO: begin
                o_sram_addr  = {r_word, 1'b0};
                o_sram_wdata = r_data[15:0];
            end
            HI: begin
                o_sram_addr  = {r_word, 1'b1};
                o_sram_wdata = r_data[31:16];
            end
            DONE:    o_ready = 1'b1;
            default: o_ready = 1'b0;
        endcase
    end

    assign o_rdata     = r_rdata;
    assign o_sram_we_n = r_we_n;
    assign o_sram_oe_n = r_oe_n;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (WAIT 2 and 1), each with an SRAM model,
// a cycle-count transaction model checked every cycle, plus literal pinned checks.
module tb_mem_access_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        rd[2], wr[2], ready[2], we_n[2], oe_n[2];
    logic [31:0] addr[2], stv[2], rdata[2];
    logic [17:0] saddr[2];
    logic [15:0] swd[2], srd[2];

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int W = (g == 0) ? 2 : 1;

        mem_access_ctrl #(.WAIT_CYCLES(W), .ADDR_W(18)) u_dut (
            .clk(clk), .rst(rst),
            .i_rd_en(rd[g]), .i_wr_en(wr[g]), .i_address(addr[g]), .i_st_val(stv[g]),
            .o_rdata(rdata[g]), .o_ready(ready[g]),
            .o_sram_addr(saddr[g]), .o_sram_wdata(swd[g]), .i_sram_rdata(srd[g]),
            .o_sram_we_n(we_n[g]), .o_sram_oe_n(oe_n[g])
        );

        logic [15:0] sram[256];
        assign srd[g] = oe_n[g] ? 16'h0 : sram[saddr[g][7:0]];
        always @(posedge clk) if (!we_n[g]) sram[saddr[g][7:0]] <= swd[g];

        // transaction model: k counts cycles since the request was accepted
        int          k;
        logic        m_wr;
        logic [16:0] m_word;
        logic [31:0] m_data, m_rd;
        logic [31:0] mmem[128];

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                k    <= 0;
                m_rd <= '0;
            end else if (k == 0) begin
                if (rd[g] | wr[g]) begin
                    k      <= 1;
                    m_wr   <= wr[g];
                    m_word <= addr[g][18:2];
                    m_data <= stv[g];
                end
            end else if (k == 2*W + 1) begin
                k <= 0;
            end else begin
                k <= k + 1;
                if (k == W && !m_wr) m_rd[15:0] <= mmem[m_word[6:0]][15:0];
                if (k == 2*W) begin
                    if (m_wr) mmem[m_word[6:0]] <= m_data;
                    else      m_rd[31:16] <= mmem[m_word[6:0]][31:16];
                end
            end
        end

        logic        e_rdy, e_we, e_oe;
        logic [17:0] e_a;
        logic [15:0] e_w;
        always_comb begin
            e_rdy = 1'b0; e_a = '0; e_w = '0; e_we = 1'b1; e_oe = 1'b1;
            if (k == 0) e_rdy = ~(rd[g] | wr[g]);
            else if (k <= W) begin
                e_a = {m_word, 1'b0}; e_w = m_data[15:0]; e_we = ~m_wr; e_oe = m_wr;
            end else if (k <= 2*W) begin
                e_a = {m_word, 1'b1}; e_w = m_data[31:16]; e_we = ~m_wr; e_oe = m_wr;
            end else e_rdy = 1'b1;
        end

        always @(negedge clk) if (!rst) begin
            chk($sformatf("i%0d.ready", g), {31'b0, ready[g]}, {31'b0, e_rdy});
            chk($sformatf("i%0d.addr", g),  {14'b0, saddr[g]}, {14'b0, e_a});
            chk($sformatf("i%0d.wdata", g), {16'b0, swd[g]},   {16'b0, e_w});
            chk($sformatf("i%0d.we_n", g),  {31'b0, we_n[g]},  {31'b0, e_we});
            chk($sformatf("i%0d.oe_n", g),  {31'b0, oe_n[g]},  {31'b0, e_oe});
            chk($sformatf("i%0d.rdata", g), rdata[g], m_rd);
        end
    end

    // per-request negedge samples, index 0 = the idle cycle that sees the request
    int          n_s;
    logic        s_rdy[16], s_we[16], s_oe[16];
    logic [17:0] s_a[16];
    logic [15:0] s_w[16];
    logic [31:0] s_rd[16];

    task automatic do_req(input int g, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        rd[g] = r; wr[g] = w; addr[g] = a; stv[g] = d;
        n_s = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            s_rdy[n_s] = ready[g]; s_we[n_s] = we_n[g]; s_oe[n_s] = oe_n[g];
            s_a[n_s] = saddr[g]; s_w[n_s] = swd[g]; s_rd[n_s] = rdata[g];
            n_s++;
            if (ready[g] || n_s == 16) break;
        end
        if (!ready[g]) begin
            n_chk++;
            $display("FAIL timeout i%0d: ready never returned high", g);
        end
    endtask

    task automatic clr(input int g);
        @(posedge clk); #1;
        rd[g] = 1'b0; wr[g] = 1'b0;
    endtask

    initial begin
        logic [17:0] ea[4];
        logic [15:0] ew[4];
        rst = 1'b1;
        for (int g = 0; g < 2; g++) begin
            rd[g] = 0; wr[g] = 0; addr[g] = '0; stv[g] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset ready", {31'b0, ready[0]}, 32'd1);
        chk("reset rdata", rdata[0], 32'h0);

        // store 0xDEADBEEF @0x10, WAIT=2
        do_req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        chk("st2 samples", n_s, 6);
        ea = '{18'd8, 18'd8, 18'd9, 18'd9};
        ew = '{16'hBEEF, 16'hBEEF, 16'hDEAD, 16'hDEAD};
        chk("st2 ready s0", {31'b0, s_rdy[0]}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("st2 ready s%0d", i+1), {31'b0, s_rdy[i+1]}, 32'd0);
            chk($sformatf("st2 addr s%0d", i+1), {14'b0, s_a[i+1]}, {14'b0, ea[i]});
            chk($sformatf("st2 wdata s%0d", i+1), {16'b0, s_w[i+1]}, {16'b0, ew[i]});
            chk($sformatf("st2 we_n s%0d", i+1), {31'b0, s_we[i+1]}, 32'd0);
        end
        chk("st2 ready s5", {31'b0, s_rdy[5]}, 32'd1);
        clr(0);

        // load back @0x10
        do_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ld3 oe_n s%0d", i), {31'b0, s_oe[i]}, 32'd0);
            chk($sformatf("ld3 we_n s%0d", i), {31'b0, s_we[i]}, 32'd1);
        end
        chk("ld3 rdata", s_rd[5], 32'hDEADBEEF);
        clr(0);

        // idle: ready high, strobes off, rdata held
        repeat (5) begin
            @(negedge clk);
            chk("idle ready", {31'b0, ready[0]}, 32'd1);
            chk("idle we_n/oe_n", {30'b0, we_n[0], oe_n[0]}, 32'd3);
            chk("idle rdata", rdata[0], 32'hDEADBEEF);
        end

        // reset during the low half of a store
        @(posedge clk); #1;
        wr[0] = 1'b1; addr[0] = 32'h40; stv[0] = 32'hA5A5A5A5;
        @(negedge clk);
        @(negedge clk);
        chk("pre-rst we_n", {31'b0, we_n[0]}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst we_n", {31'b0, we_n[0]}, 32'd1);
        chk("rst ready", {31'b0, ready[0]}, 32'd0);
        chk("rst rdata", rdata[0], 32'h0);
        wr[0] = 1'b0;
        #1;
        chk("rst ready idle", {31'b0, ready[0]}, 32'd1);
        @(posedge clk); #1 rst = 1'b0;

        // rd_en and wr_en together: store
        do_req(0, 1'b1, 1'b1, 32'h20, 32'h12345678);
        ea = '{18'd16, 18'd16, 18'd17, 18'd17};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("both addr s%0d", i+1), {14'b0, s_a[i+1]}, {14'b0, ea[i]});
            chk($sformatf("both strobes s%0d", i+1), {30'b0, s_we[i+1], s_oe[i+1]}, 32'd1);
        end
        chk("both rdata", s_rd[5], 32'h0);
        clr(0);
        do_req(0, 1'b1, 1'b0, 32'h20, 32'h0);
        chk("ld 0x20 rdata", s_rd[n_s-1], 32'h12345678);
        clr(0);

        // WAIT=1 instance: seed, then back-to-back load and store
        do_req(1, 1'b0, 1'b1, 32'h10, 32'hCAFEF00D);
        clr(1);
        do_req(1, 1'b1, 1'b0, 32'h10, 32'h0);
        chk("b2b ld samples", n_s, 4);
        chk("b2b ld ready", {28'b0, s_rdy[0], s_rdy[1], s_rdy[2], s_rdy[3]}, 32'b0001);
        chk("b2b ld rdata", s_rd[3], 32'hCAFEF00D);
        do_req(1, 1'b0, 1'b1, 32'h14, 32'h0BADC0DE);
        chk("b2b st ready", {28'b0, s_rdy[0], s_rdy[1], s_rdy[2], s_rdy[3]}, 32'b0001);
        chk("b2b st addr lo", {14'b0, s_a[1]}, 32'd10);
        chk("b2b st addr hi", {14'b0, s_a[2]}, 32'd11);
        clr(1);
        do_req(1, 1'b1, 1'b0, 32'h14, 32'h0);
        chk("b2b readback", s_rd[n_s-1], 32'h0BADC0DE);
        clr(1);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
